sr_latch_ctrl: RTL and testbench

Synchronous sequencer for the cross-coupled `sr_latch` storage cell. It accepts set, reset and toggle commands over a valid/ready handshake and drives the latch `S`/`R` inputs with pulses of fixed width. It guarantees `S` and `R` are never high together and enforces a low gap between pulses. After every pulse it reads back both latch outputs, checks them against the expected value and flags any mismatch.

---
 rtl/sr_ctrl_pkg.sv | 30 +++
 rtl/sr_latch_ctrl_if.sv | 29 ++
 rtl/sr_latch.sv | 24 ++
 rtl/sr_pulse_timer.sv | 30 +++
 rtl/sr_latch_ctrl.sv | 141 ++++++++++++++
 tb/tb_sr_latch_ctrl.sv | 268 ++++++++++++++++++++++++++
 6 files changed

// File: rtl/sr_ctrl_pkg.sv
// Shared types for the sr_latch sequencer: FSM states, command encodings
// and the command-to-target decode.
package sr_ctrl_pkg;

   typedef enum logic [2:0] {
      INIT,
      IDLE,
      DRIVE,
      GAP,
      CHECK
   } state_e;

   typedef enum logic [1:0] {
      OP_NOP = 2'b00,
      OP_SET = 2'b01,
      OP_RST = 2'b10,
      OP_TGL = 2'b11
   } op_e;

   // Value the latch should hold once the command's pulse has landed.
   function automatic logic op_target(op_e op, logic q_exp);
      case (op)
         OP_SET:  return 1'b1;
         OP_RST:  return 1'b0;
         OP_TGL:  return ~q_exp;
         default: return q_exp;
      endcase
   endfunction

endpackage

// File: rtl/sr_latch_ctrl_if.sv
// Command handshake plus latch drive/readback bundle for sr_latch_ctrl.
// master: command source and latch side; slave: the controller.
interface sr_latch_ctrl_if;
   import sr_ctrl_pkg::*;

   logic cmd_valid;
   op_e  cmd_op;
   logic cmd_ready;
   logic err_clr;
   logic s;
   logic r;
   logic q;
   logic qn;
   logic q_exp;
   logic done;
   logic busy;
   logic err;

   modport master (
      output cmd_valid, cmd_op, err_clr, q, qn,
      input  cmd_ready, s, r, q_exp, done, busy, err
   );

   modport slave (
      input  cmd_valid, cmd_op, err_clr, q, qn,
      output cmd_ready, s, r, q_exp, done, busy, err
   );

endinterface

// File: rtl/sr_latch.sv
// Behavioural model of the cross-coupled S/R storage cell driven by
// sr_latch_ctrl. S and R are never high together in this system.
module sr_latch (
   input  logic s_i,
   input  logic r_i,
   output logic q_o,
   output logic qn_o
);

   logic q_q;

   // Transparent while either input is high, holds otherwise.
   // NOTE: this is the one deliberate latch in the design; it is the
   // storage cell itself, not a missing default.
   always_latch begin
      if (s_i || r_i) begin
         q_q = s_i;
      end
   end

   assign q_o  = q_q;
   assign qn_o = ~q_q;

endmodule

// File: rtl/sr_pulse_timer.sv
// Loadable down-counter shared by the pulse and gap phases. Counts down to
// 1 and holds there; expire_o flags the last cycle of the phase.
module sr_pulse_timer #(
   parameter int W = 3
) (
   input  logic         clk,
   input  logic         load_i,
   input  logic [W-1:0] load_val_i,
   input  logic         en_i,
   output logic         expire_o
);

   logic [W-1:0] cnt_q;

   // Load on phase entry, otherwise count down without wrapping below 1.
   // NOTE: no reset branch here; the parent holds load_i high during reset,
   // so the count is always defined before it is used.
   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments for all clocked state, so every
      // register samples pre-edge values regardless of block ordering.
      if (load_i) begin
         cnt_q <= load_val_i;
      end else if (en_i && (cnt_q > W'(1))) begin
         cnt_q <= cnt_q - W'(1);
      end
   end

   assign expire_o = (cnt_q == W'(1));

endmodule

// File: rtl/sr_latch_ctrl.sv
// Sequencer for the sr_latch cell: accepts SET/RESET/TOGGLE/NOP commands,
// drives fixed-width S/R pulses followed by a low gap, then reads back Q/QN
// and raises a sticky error on mismatch. All outputs are registered.
module sr_latch_ctrl
   import sr_ctrl_pkg::*;
#(
   parameter int PULSE_CYCLES = 4,
   parameter int GAP_CYCLES   = 2
) (
   input logic            clk,
   input logic            rst,
   sr_latch_ctrl_if.slave bus
);

   localparam int MAX_CYCLES = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
   localparam int CNT_W      = $clog2(MAX_CYCLES + 1);
   localparam logic [CNT_W-1:0] PULSE_LOAD = CNT_W'(PULSE_CYCLES);
   localparam logic [CNT_W-1:0] GAP_LOAD   = CNT_W'(GAP_CYCLES);

   state_e state_q, state_d;
   logic   tgt_q, tgt_d;         // value being driven in DRIVE
   logic   q_exp_q, q_exp_d;
   logic   chk_en_q, chk_en_d;   // CHECK compares readback (off for NOP)
   logic   cmd_q, cmd_d;         // CHECK completes a command (off for INIT)

   logic s_q, r_q, done_q, busy_q, ready_q, err_q;

   logic             timer_load;
   logic [CNT_W-1:0] timer_val;
   logic             timer_expire;
   logic             mismatch;

   assign mismatch = (bus.q != q_exp_q) || (bus.qn != ~q_exp_q);

   // Next-state, command capture and phase-timer load decisions.
   always_comb begin
      // NOTE: every variable gets a default first so no path leaves one
      // unassigned, which would otherwise infer a latch.
      state_d    = state_q;
      tgt_d      = tgt_q;
      q_exp_d    = q_exp_q;
      chk_en_d   = chk_en_q;
      cmd_d      = cmd_q;
      timer_load = 1'b0;
      timer_val  = PULSE_LOAD;

      case (state_q)
         // busy_q is still low in the first cycle after reset; the pulse
         // only starts counting once r is actually high.
         INIT:  if (busy_q && timer_expire) state_d = GAP;
         IDLE: begin
            if (bus.cmd_valid && ready_q) begin
               cmd_d = 1'b1;
               if (bus.cmd_op == OP_NOP) begin
                  state_d  = CHECK;
                  chk_en_d = 1'b0;
               end else begin
                  state_d  = DRIVE;
                  chk_en_d = 1'b1;
                  tgt_d    = op_target(bus.cmd_op, q_exp_q);
                  q_exp_d  = tgt_d;
               end
            end
         end
         DRIVE: if (timer_expire) state_d = GAP;
         GAP:   if (timer_expire) state_d = CHECK;
         CHECK: state_d = IDLE;
         default: state_d = INIT;
      endcase

      // Timer reloads on entry to a timed phase; reset preloads the INIT pulse.
      if (rst) begin
         timer_load = 1'b1;
         timer_val  = PULSE_LOAD;
      end else if ((state_d != state_q) && ((state_d == DRIVE) || (state_d == GAP))) begin
         timer_load = 1'b1;
         timer_val  = (state_d == GAP) ? GAP_LOAD : PULSE_LOAD;
      end
   end

   // State and captured-command registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= INIT;
         tgt_q    <= 1'b0;
         q_exp_q  <= 1'b0;
         chk_en_q <= 1'b1;
         cmd_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         tgt_q    <= tgt_d;
         q_exp_q  <= q_exp_d;
         chk_en_q <= chk_en_d;
         cmd_q    <= cmd_d;
      end
   end

   // Registered outputs, derived from the state being entered so they line
   // up with the phase they belong to. s and r decode mutually exclusive states.
   always_ff @(posedge clk) begin
      if (rst) begin
         s_q     <= 1'b0;
         r_q     <= 1'b0;
         done_q  <= 1'b0;
         busy_q  <= 1'b0;
         ready_q <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         s_q     <= (state_d == DRIVE) && tgt_d;
         r_q     <= (state_d == INIT) || ((state_d == DRIVE) && !tgt_d);
         done_q  <= (state_d == CHECK) && cmd_d;
         busy_q  <= (state_d != IDLE);
         ready_q <= (state_d == IDLE);
         // A fresh mismatch takes priority over a clear in the same cycle.
         if ((state_q == CHECK) && chk_en_q && mismatch) begin
            err_q <= 1'b1;
         end else if (bus.err_clr) begin
            err_q <= 1'b0;
         end
      end
   end

   sr_pulse_timer #(
      .W (CNT_W)
   ) u_timer (
      .clk        (clk),
      .load_i     (timer_load),
      .load_val_i (timer_val),
      .en_i       (busy_q),
      .expire_o   (timer_expire)
   );

   assign bus.s         = s_q;
   assign bus.r         = r_q;
   assign bus.done      = done_q;
   assign bus.busy      = busy_q;
   assign bus.cmd_ready = ready_q;
   assign bus.err       = err_q;
   assign bus.q_exp     = q_exp_q;

endmodule

// File: tb/tb_sr_latch_ctrl.sv
// Bench for sr_latch_ctrl wired to a real sr_latch. A cycle-count model of
// each operation predicts every output on every cycle.
module tb_sr_latch_ctrl;
   import sr_ctrl_pkg::*;

   localparam int P   = 4;
   localparam int G   = 2;
   localparam int CHK = P + G + 1;

   typedef enum {K_RST, K_INIT, K_IDLE, K_CMD, K_NOP} kind_e;

   logic clk = 1'b0;
   logic rst;
   logic force_q0;
   logic latch_q, latch_qn;

   int n_checks = 0;
   int n_errors = 0;

   kind_e m_kind;
   int    m_c;
   bit    m_tgt, m_qexp, m_err;

   always #5 clk = ~clk;

   sr_latch_ctrl_if bus ();

   sr_latch u_latch (
      .s_i  (bus.s),
      .r_i  (bus.r),
      .q_o  (latch_q),
      .qn_o (latch_qn)
   );

   assign bus.q  = force_q0 ? 1'b0 : latch_q;
   assign bus.qn = latch_qn;

   sr_latch_ctrl #(
      .PULSE_CYCLES (P),
      .GAP_CYCLES   (G)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp_v);
      n_checks++;
      if (act !== exp_v) begin
         n_errors++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, act, exp_v, $time);
      end
   endtask

   // Advance the model by one rising edge using the inputs the bench applied.
   task automatic model_edge();
      bit chk;
      if (rst) begin
         m_kind = K_RST;
         m_c    = 0;
         m_qexp = 1'b0;
         m_err  = 1'b0;
         return;
      end
      chk = ((m_kind == K_INIT) || (m_kind == K_CMD)) && (m_c == CHK);
      // With the latch settled, a mismatch only appears when Q is forced low
      // while the latch is expected to hold 1.
      if (chk && force_q0 && m_qexp) m_err = 1'b1;
      else if (bus.err_clr)          m_err = 1'b0;
      case (m_kind)
         K_RST: begin
            m_kind = K_INIT;
            m_c    = 1;
         end
         K_IDLE: begin
            if (bus.cmd_valid) begin
               m_c = 1;
               if (bus.cmd_op == OP_NOP) begin
                  m_kind = K_NOP;
               end else begin
                  m_kind = K_CMD;
                  case (bus.cmd_op)
                     OP_SET:  m_tgt = 1'b1;
                     OP_RST:  m_tgt = 1'b0;
                     default: m_tgt = ~m_qexp;
                  endcase
                  m_qexp = m_tgt;
               end
            end
         end
         K_NOP: begin
            m_kind = K_IDLE;
            m_c    = 0;
         end
         default: begin
            if (m_c == CHK) begin
               m_kind = K_IDLE;
               m_c    = 0;
            end else begin
               m_c++;
            end
         end
      endcase
   endtask

   task automatic compare_outputs();
      bit drive, e_s, e_r, e_done, e_busy, e_ready;
      drive   = ((m_kind == K_INIT) || (m_kind == K_CMD)) && (m_c >= 1) && (m_c <= P);
      e_s     = drive && (m_kind == K_CMD) && m_tgt;
      e_r     = drive && ((m_kind == K_INIT) || !m_tgt);
      e_done  = ((m_kind == K_CMD) && (m_c == CHK)) || (m_kind == K_NOP);
      e_busy  = (m_kind == K_INIT) || (m_kind == K_CMD) || (m_kind == K_NOP);
      e_ready = (m_kind == K_IDLE);
      check("s",         32'(bus.s),         32'(e_s));
      check("r",         32'(bus.r),         32'(e_r));
      check("s_and_r",   32'(bus.s & bus.r), 32'd0);
      check("done",      32'(bus.done),      32'(e_done));
      check("busy",      32'(bus.busy),      32'(e_busy));
      check("cmd_ready", 32'(bus.cmd_ready), 32'(e_ready));
      check("q_exp",     32'(bus.q_exp),     32'(m_qexp));
      check("err",       32'(bus.err),       32'(m_err));
   endtask

   // One clock: model follows the edge, outputs compared on the falling edge.
   task automatic step();
      @(posedge clk);
      model_edge();
      @(negedge clk);
      compare_outputs();
   endtask

   task automatic wait_idle();
      for (int i = 0; (i < 40) && (m_kind != K_IDLE); i++) step();
      if (m_kind != K_IDLE) check("idle_timeout", 32'd0, 32'd1);
   endtask

   task automatic issue(input op_e op);
      wait_idle();
      bus.cmd_valid = 1'b1;
      bus.cmd_op    = op;
      step();
      bus.cmd_valid = 1'b0;
   endtask

   // Issue a command and measure acceptance-to-done latency in cycles.
   task automatic timed_cmd(input op_e op, input int want_lat, input bit want_qexp);
      int n;
      issue(op);
      n = 1;
      while (!bus.done && (n < 20)) begin
         step();
         n++;
      end
      check("done_latency", 32'(n), 32'(want_lat));
      check("q_exp_after", 32'(bus.q_exp), 32'(want_qexp));
   endtask

   // Release reset and count cycles until cmd_ready rises.
   task automatic release_reset(input string tag);
      int n;
      rst = 1'b0;
      n   = 0;
      do begin
         step();
         n++;
      end while (!bus.cmd_ready && (n < 20));
      check(tag, 32'(n), 32'(P + G + 2));
   endtask

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst           = 1'b1;
      force_q0      = 1'b0;
      bus.cmd_valid = 1'b0;
      bus.cmd_op    = OP_NOP;
      bus.err_clr   = 1'b0;
      m_kind        = K_RST;
      m_c           = 0;
      m_tgt         = 1'b0;
      m_qexp        = 1'b0;
      m_err         = 1'b0;

      // Reset state and the INIT sequence.
      repeat (3) step();
      release_reset("init_ready_rise");
      check("init_err",   32'(bus.err),   32'd0);
      check("init_q_exp", 32'(bus.q_exp), 32'd0);

      // SET, RESET, TOGGLE back-to-back.
      timed_cmd(OP_SET, CHK, 1'b1);
      timed_cmd(OP_RST, CHK, 1'b0);
      timed_cmd(OP_TGL, CHK, 1'b1);

      // cmd_valid held high with a changing op while busy.
      wait_idle();
      bus.cmd_valid = 1'b1;
      for (int i = 0; i < 40; i++) begin
         bus.cmd_op = op_e'($urandom_range(0, 3));
         step();
      end
      bus.cmd_valid = 1'b0;

      // Q stuck at 0 during a SET.
      issue(OP_RST);
      wait_idle();
      force_q0 = 1'b1;
      issue(OP_SET);
      wait_idle();
      check("err_set", 32'(bus.err), 32'd1);
      repeat (3) step();
      check("err_sticky", 32'(bus.err), 32'd1);

      // Clear requested in the same cycle as a fresh mismatch.
      issue(OP_SET);
      for (int i = 0; (i < 20) && !((m_kind == K_CMD) && (m_c == CHK)); i++) step();
      bus.err_clr = 1'b1;
      step();
      bus.err_clr = 1'b0;
      check("err_set_wins", 32'(bus.err), 32'd1);

      // Clear alone.
      force_q0 = 1'b0;
      wait_idle();
      bus.err_clr = 1'b1;
      step();
      bus.err_clr = 1'b0;
      check("err_clr", 32'(bus.err), 32'd0);

      // Reset in cycle 2 of a SET pulse.
      issue(OP_SET);
      step();
      rst = 1'b1;
      step();
      check("rst_drops_s", 32'(bus.s), 32'd0);
      check("rst_q_exp",   32'(bus.q_exp), 32'd0);
      release_reset("reinit_ready_rise");

      // NOP: done in cycle 1, ready in cycle 2, nothing else moves.
      timed_cmd(OP_SET, CHK, 1'b1);
      timed_cmd(OP_NOP, 1, m_qexp);
      step();
      check("nop_ready", 32'(bus.cmd_ready), 32'd1);

      // Randomised traffic with occasional faults, clears and resets.
      for (int i = 0; i < 1500; i++) begin
         bus.cmd_valid = ($urandom_range(0, 9) < 6);
         bus.cmd_op    = op_e'($urandom_range(0, 3));
         bus.err_clr   = ($urandom_range(0, 15) == 0);
         if ($urandom_range(0, 49) == 0) force_q0 = ~force_q0;
         rst = ($urandom_range(0, 199) == 0);
         step();
      end
      rst           = 1'b0;
      bus.cmd_valid = 1'b0;
      bus.err_clr   = 1'b0;
      force_q0      = 1'b0;
      repeat (12) step();

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
